// File: rtl/game_flow_ctrl.sv
// Game sequencer: TITLE -> SELECT -> PLAY -> OVER, with the round countdown and round-start reset.
// Optional pause support in PLAY is enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl #(
  parameter int         ROUND_SECONDS    = 180,
  parameter int         FRAMES_PER_SEC   = 60,
  parameter int         OVER_HOLD_FRAMES = 120,
  parameter logic [7:0] KEY_ENTER        = 8'h28,
  parameter logic [7:0] KEY_UP           = 8'h1A,
  parameter logic [7:0] KEY_DOWN         = 8'h16,
  parameter logic [7:0] KEY_PAUSE        = 8'h13
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Frame_Tick,
  input  logic [15:0] Keycode,
  input  logic        P1_Hit,
  input  logic        P2_Hit,
  output logic [1:0]  state,
  output logic        Player_choose,
  output logic        Winner,
  output logic        Draw,
  output logic        Game_Reset,
  output logic [7:0]  Time_Left,
  output logic        Paused
);

  localparam int SEC_W  = $clog2(FRAMES_PER_SEC + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(FRAMES_PER_SEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD_FRAMES);
  localparam logic [7:0]        TL_LOAD  = 8'(ROUND_SECONDS);

  typedef enum logic [1:0] {
    S_TITLE  = 2'b00,
    S_SELECT = 2'b01,
    S_PLAY   = 2'b10,
    S_OVER   = 2'b11
  } state_t;

  state_t            st;
  logic [15:0]       key_prev;
  logic [SEC_W-1:0]  sec_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  function automatic logic key_in(input logic [15:0] kc, input logic [7:0] k);
    return (kc[7:0] == k) || (kc[15:8] == k);
  endfunction

  // A press is a key that appears now in either slot but was in neither slot last cycle.
  logic enter_press, up_press, down_press;
  assign enter_press = key_in(Keycode, KEY_ENTER) && !key_in(key_prev, KEY_ENTER);
  assign up_press    = key_in(Keycode, KEY_UP)    && !key_in(key_prev, KEY_UP);
  assign down_press  = key_in(Keycode, KEY_DOWN)  && !key_in(key_prev, KEY_DOWN);

`ifdef GAME_PAUSE_EN
  logic pause_press;
  assign pause_press = key_in(Keycode, KEY_PAUSE) && !key_in(key_prev, KEY_PAUSE);
`endif

  logic hits_live;
  assign hits_live = !Paused;

  assign state = st;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st            <= S_TITLE;
      Player_choose <= 1'b0;
      Winner        <= 1'b0;
      Draw          <= 1'b0;
      Game_Reset    <= 1'b0;
      Time_Left     <= TL_LOAD;
      Paused        <= 1'b0;
      sec_cnt       <= '0;
      hold_cnt      <= '0;
      key_prev      <= '0;
    end else begin
      key_prev   <= Keycode;
      Game_Reset <= 1'b0;
      case (st)
        S_TITLE: begin
          if (enter_press) st <= S_SELECT;
        end
        S_SELECT: begin
          if (up_press && !down_press)      Player_choose <= 1'b0;
          else if (down_press && !up_press) Player_choose <= 1'b1;
          if (enter_press) begin
            st         <= S_PLAY;
            Game_Reset <= 1'b1;
            Time_Left  <= TL_LOAD;
            sec_cnt    <= '0;
            Winner     <= 1'b0;
            Draw       <= 1'b0;
            Paused     <= 1'b0;
          end
        end
        S_PLAY: begin
          // Hits outrank the timeout, so a hit on the final tick still names a winner.
          if (hits_live && (P1_Hit || P2_Hit)) begin
            st       <= S_OVER;
            hold_cnt <= '0;
            Paused   <= 1'b0;
            if (P1_Hit && P2_Hit) Draw   <= 1'b1;
            else if (P1_Hit)      Winner <= 1'b1;
            else                  Winner <= 1'b0;
          end else if (Time_Left == 8'd0) begin
            st       <= S_OVER;
            hold_cnt <= '0;
            Paused   <= 1'b0;
            Draw     <= 1'b1;
          end else begin
            if (Frame_Tick && !Paused) begin
              if (sec_cnt == SEC_LAST) begin
                sec_cnt   <= '0;
                Time_Left <= Time_Left - 8'd1;
              end else begin
                sec_cnt <= sec_cnt + 1'b1;
              end
            end
`ifdef GAME_PAUSE_EN
            if (pause_press) Paused <= !Paused;
`else
            Paused <= 1'b0;
`endif
          end
        end
        S_OVER: begin
          if (Frame_Tick && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          if (enter_press && hold_cnt == HOLD_MAX) begin
            st     <= S_TITLE;
            Winner <= 1'b0;
            Draw   <= 1'b0;
          end
        end
        default: st <= S_TITLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: menu flow, countdown, hit priority, OVER hold and reset.
module tb_game_flow_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Frame_Tick = 1'b0;
  logic [15:0] Keycode = '0;
  logic        P1_Hit = 1'b0;
  logic        P2_Hit = 1'b0;
  logic [1:0]  state;
  logic        Player_choose, Winner, Draw, Game_Reset, Paused;
  logic [7:0]  Time_Left;

  int tests = 0;
  int fails = 0;

  game_flow_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Frame_Tick(Frame_Tick), .Keycode(Keycode),
    .P1_Hit(P1_Hit), .P2_Hit(P2_Hit), .state(state), .Player_choose(Player_choose),
    .Winner(Winner), .Draw(Draw), .Game_Reset(Game_Reset), .Time_Left(Time_Left),
    .Paused(Paused)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [15:0] kc);
    Keycode = kc;
    cyc();
    Keycode = '0;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      Frame_Tick = 1'b1;
      cyc();
      Frame_Tick = 1'b0;
      cyc();
    end
  endtask

  task automatic to_play();
    press(16'h0028);
    press(16'h0028);
  endtask

  task automatic leave_over();
    frames(120);
    press(16'h0028);
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    cyc();
    cyc();
    Reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_pc", Player_choose, 0);
    check("rst_winner", Winner, 0);
    check("rst_draw", Draw, 0);
    check("rst_game_reset", Game_Reset, 0);
    check("rst_time_left", Time_Left, 180);
    check("rst_paused", Paused, 0);

    // Held Enter gives one transition
    Keycode = 16'h0028;
    cyc();
    check("t2_to_select", state, 1);
    repeat (9) cyc();
    check("t2_held_no_repeat", state, 1);
    check("t2_no_game_reset", Game_Reset, 0);
    Keycode = '0;
    cyc();

    // Player selection
    press(16'h161A);
    check("t3_updown_pc0", Player_choose, 0);
    press(16'h0016);
    check("t3_down", Player_choose, 1);
    press(16'h161A);
    check("t3_updown_pc1", Player_choose, 1);
    press(16'h001A);
    check("t3_up", Player_choose, 0);
    press(16'h1600);
    check("t3_down_hi_slot", Player_choose, 1);

    // Enter into PLAY pulses Game_Reset exactly once
    Keycode = 16'h0028;
    cyc();
    check("t2_play", state, 2);
    check("t2_gr_pulse", Game_Reset, 1);
    check("t2_tl_load", Time_Left, 180);
    Keycode = '0;
    cyc();
    check("t2_gr_clear", Game_Reset, 0);
    check("t2_pc_kept", Player_choose, 1);

    // Full countdown to timeout
    frames(59);
    check("t4_59_frames", Time_Left, 180);
    frames(1);
    check("t4_1s", Time_Left, 179);
    for (int s = 1; s < 180; s++) begin
      frames(60);
      if (s == 90 || s == 179) check("t4_countdown", Time_Left, 179 - s);
    end
    check("t4_timeout_state", state, 3);
    check("t4_timeout_draw", Draw, 1);
    check("t4_timeout_winner", Winner, 0);
    check("t4_gr_low", Game_Reset, 0);

    // OVER hold: early Enter discarded, accepted once 120 ticks seen
    frames(50);
    press(16'h0028);
    check("t5_enter_50", state, 3);
    frames(69);
    press(16'h0028);
    check("t5_enter_119", state, 3);
    frames(1);
    press(16'h0028);
    check("t5_enter_120", state, 0);
    check("t5_draw_clear", Draw, 0);

    // Hit on the final tick beats timeout
    to_play();
    check("t4b_play", state, 2);
    frames(10799);
    check("t4b_tl_1", Time_Left, 1);
    Frame_Tick = 1'b1;
    P2_Hit = 1'b1;
    cyc();
    Frame_Tick = 1'b0;
    P2_Hit = 1'b0;
    check("t4b_state", state, 3);
    check("t4b_winner", Winner, 0);
    check("t4b_draw", Draw, 0);
    cyc();
    leave_over();
    check("t4b_back_title", state, 0);

    // Simultaneous hits draw
    to_play();
    P1_Hit = 1'b1;
    P2_Hit = 1'b1;
    cyc();
    P1_Hit = 1'b0;
    P2_Hit = 1'b0;
    check("t5_both_state", state, 3);
    check("t5_both_draw", Draw, 1);
    leave_over();

    // Player 1 hit -> player 2 wins
    to_play();
    P1_Hit = 1'b1;
    cyc();
    P1_Hit = 1'b0;
    check("p1hit_state", state, 3);
    check("p1hit_winner", Winner, 1);
    check("p1hit_draw", Draw, 0);
    leave_over();
    check("p1hit_winner_clear", Winner, 0);

    // Pause behaviour
    to_play();
`ifdef GAME_PAUSE_EN
    press(16'h0013);
    check("t6_paused", Paused, 1);
    frames(300);
    P1_Hit = 1'b1;
    cyc();
    P1_Hit = 1'b0;
    check("t6_tl_frozen", Time_Left, 180);
    check("t6_state_play", state, 2);
    press(16'h1300);
    check("t6_resumed", Paused, 0);
    frames(60);
    check("t6_tl_running", Time_Left, 179);
`else
    press(16'h0013);
    check("t6_no_pause", Paused, 0);
    frames(60);
    check("t6_tl_running", Time_Left, 179);
`endif

    // Reset mid-PLAY
    frames(79 * 60);
    check("t1_tl_100", Time_Left, 100);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check("t1_state", state, 0);
    check("t1_tl", Time_Left, 180);
    check("t1_gr", Game_Reset, 0);
    check("t1_paused", Paused, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
